seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle unsigned restoring divider built around the team's magnitude/sign subtraction stage. Each cycle it shifts the partial remainder, feeds the remainder and divisor into that subtractor, and uses the returned sign bit to decide the quotient bit and whether to restore. It sits directly upstream of the subtractor: it supplies both operands every iteration and consumes the difference and sign that the subtractor returns. Operands are taken in with a start/done handshake, and results are held until the next operation.

## Interface
Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (minimum 2).

Ports:
- clk  in  1  the single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new division; sampled only when not busy.
- dividend  in  WIDTH  unsigned dividend; sampled on the accepted start edge.
- divisor  in  WIDTH  unsigned divisor; sampled on the accepted start edge.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  out  WIDTH  unsigned quotient; held until the next accepted start.
- remainder  out  WIDTH  unsigned remainder; held until the next accepted start.
- div_by_zero  out  1  flags that the divisor was zero; held alongside the results.

## Operation
- States:
  - IDLE: waiting for start.
  - CALC: iterating.
  - DONE: one cycle, done=1.
- IDLE or DONE with start=1 → CALC:
  - Latch the divisor.
  - Load the shift register with the dividend.
  - Clear the partial remainder and the iteration counter.
  - Clear div_by_zero.
- CALC iteration, one per cycle, WIDTH iterations:
  - Form rem_sh = {rem, dividend MSB}. It is WIDTH+1 bits wide.
  - Subtract rem_sh - {0, divisor} in the WIDTH+1-bit subtractor.
  - sign=0: rem ← diff, and the quotient bit shifted in is 1.
  - sign=1: rem ← rem_sh (restore), and the quotient bit shifted in is 0.
  - The quotient bit enters at the LSB of the shift register as the dividend bit leaves at the MSB.
- Counter leaves CALC after WIDTH iterations → DONE.
  - The shift register holds the quotient, and rem[WIDTH-1:0] is the remainder.
- DONE with start=0 → IDLE. DONE with start=1 → CALC, back-to-back.
- start while in CALC is ignored, with no queueing.
- Invariant: the result is exact for all non-zero divisors, i.e. dividend = quotient*divisor + remainder with remainder < divisor.
- Divisor 0 without the check feature:
  - Every trial succeeds.
  - The result is quotient = all-ones, remainder = dividend.

## Timing
- Reset values:
  - State IDLE; busy=0; done=0; div_by_zero=0.
  - quotient=0; remainder=0; internal remainder, shift register and counter all 0.
- Start accepted at edge E0: busy=1 from E0 through E(WIDTH).
- Iterations occur at edges E1..E(WIDTH).
- done=1 and busy=0 in the cycle after E(WIDTH). Latency is WIDTH+1 edges.
- quotient/remainder outputs update only on entry to DONE. They are stable during CALC, showing the previous results.
- Reset asserted mid-operation:
  - Immediately returns all state and outputs to their reset values.
  - No done pulse is produced.
  - The first start after rst_n deasserts is accepted normally.

## Configuration
- SEQ_DIVIDER_ZERO_CHECK_EN defined, and divisor is 0 at the accepted start:
  - Go IDLE/DONE → DONE directly at E0. done=1 in the cycle after E0.
  - quotient = all-ones, remainder = dividend, div_by_zero=1.
- SEQ_DIVIDER_ZERO_CHECK_EN undefined:
  - No special case. A zero divisor takes the full WIDTH+1 latency.
  - The algorithm yields the same quotient/remainder, and div_by_zero is tied to 0.

## Structure
- Package seq_div_pkg holds:
  - The state enum (IDLE, CALC, DONE).
  - The default width constant.
  - The counter width, clog2(WIDTH+1).
- One sub-module, trial_sub: a WIDTH+1-bit magnitude/sign subtractor with inputs a, b and outputs diff and sign (1 when a<b).
- The divider FSM, counter and shift registers stay in seq_divider.

## Test plan
All scenarios use WIDTH=8.
- 200/7 → done 9 edges after start; quotient=28, remainder=4, div_by_zero=0.
- 255/1 → quotient=255, remainder=0. 5/9 → quotient=0, remainder=5. 255/255 → quotient=1, remainder=0.
- 0/0 and 77/0:
  - With the macro: done 1 edge after start, quotient=255, remainder=dividend, div_by_zero=1.
  - Without the macro: done after 9 edges, same quotient/remainder, div_by_zero=0.
- start held high through 100/3 → the second start is ignored during CALC, results are quotient=33, remainder=1. A new start during the done cycle with 9/2 → the back-to-back result is quotient=4, remainder=1.
- rst_n pulsed low at iteration 4 of 200/7 → all outputs 0 immediately, no done pulse. A following 50/6 → quotient=8, remainder=2.
- Random sweep of 2000 dividend/divisor pairs with divisor ≠ 0 → matches the reference model; busy/done pulse shape is checked every operation.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and constants for the sequential divider
//
// Purpose : holds the divider FSM state encoding, the default operand width and
//           the helper that sizes the iteration counter.
// Ports   : none (package).
// Config  : none here; the optional zero-divisor shortcut is selected in
//           rtl/seq_divider.sv by SEQ_DIVIDER_ZERO_CHECK_EN.

package seq_div_pkg;

  // Default operand / quotient / remainder width.
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of a counter that can hold the values 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/done handshake and operand/result bundle of the divider
//
// Purpose : groups the divider request and result signals.
// Signals : start, dividend[WIDTH], divisor[WIDTH]      (requester -> divider)
//           busy, done, quotient[WIDTH], remainder[WIDTH],
//           div_by_zero                                 (divider -> requester)
// Modports: master = requester side, slave = divider side.

interface seq_divider_if
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_trial_sub.sv
// rtl/seq_divider_trial_sub.sv - magnitude/sign trial subtractor for the restoring divider
//
// Purpose : computes a - b on WIDTH-bit unsigned operands and reports whether
//           the subtraction borrowed.
// Ports   : a[WIDTH]     in   minuend (shifted partial remainder)
//           b[WIDTH]     in   subtrahend (zero-extended divisor)
//           diff[WIDTH]  out  a - b modulo 2**WIDTH
//           sign         out  1 when a < b (trial failed, restore needed)

module trial_sub
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH + 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             sign
);

  // One extra bit captures the borrow out of the subtraction.
  logic [WIDTH:0] full;

  assign full = {1'b0, a} - {1'b0, b};
  assign diff = full[WIDTH-1:0];
  assign sign = full[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider with start/done handshake
//
// Purpose : divides bus.dividend by bus.divisor, one quotient bit per clock,
//           WIDTH iterations; results are held until the next accepted start.
// Ports   : clk          in   clock, rising edge
//           rst_n        in   asynchronous active-low reset
//           bus (slave)  start/dividend/divisor in,
//                        busy/done/quotient/remainder/div_by_zero out
// Config  : SEQ_DIVIDER_ZERO_CHECK_EN - when defined, a zero divisor skips the
//           iterations, goes straight to DONE and raises div_by_zero. When
//           undefined, a zero divisor runs the full algorithm (quotient all-ones,
//           remainder = dividend) and div_by_zero is tied to 0.

module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_CALC = ST_CALC;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]       state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] rem_q,     rem_d;      // partial remainder
  logic [WIDTH-1:0] shreg_q,   shreg_d;    // dividend bits out, quotient bits in
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q,    quot_d;     // held result registers
  logic [WIDTH-1:0] remout_q,  remout_d;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  logic             dbz_q,     dbz_d;
`endif

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             sign;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] shreg_next;
  logic             last_iter;
  logic             accept;
  // The top bit of the next remainder is always 0: a successful trial leaves
  // diff < divisor, a restore keeps rem_sh < divisor, and with a zero divisor
  // the remainder only ever holds a WIDTH-bit prefix of the dividend.
  logic             rem_msb_unused;

  // Shift the next dividend bit into the partial remainder for this trial.
  assign rem_sh = {rem_q, shreg_q[WIDTH-1]};

  trial_sub #(
    .WIDTH (WIDTH + 1)
  ) u_trial_sub (
    .a    (rem_sh),
    .b    ({1'b0, divisor_q}),
    .diff (diff),
    .sign (sign)
  );

  assign rem_next       = sign ? rem_sh : diff;
  assign rem_msb_unused = rem_next[WIDTH];
  assign shreg_next     = {shreg_q[WIDTH-2:0], ~sign};
  assign last_iter      = (cnt_q == CW'(WIDTH - 1));
  assign accept         = bus.start && (state_q != S_CALC);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    shreg_d   = shreg_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    remout_d  = remout_q;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
    dbz_d     = dbz_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d   = S_CALC;
          divisor_d = bus.divisor;
          shreg_d   = bus.dividend;
          rem_d     = '0;
          cnt_d     = '0;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
          dbz_d     = 1'b0;
          // Zero divisor: publish the same result the loop would produce,
          // without spending the iterations.
          if (bus.divisor == '0) begin
            state_d  = S_DONE;
            quot_d   = '1;
            remout_d = bus.dividend;
            dbz_d    = 1'b1;
          end
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        rem_d   = rem_next[WIDTH-1:0];
        shreg_d = shreg_next;
        cnt_d   = cnt_q + CW'(1);
        // Results are published only on entry to DONE, so the outputs keep
        // showing the previous operation throughout CALC.
        if (last_iter) begin
          state_d  = S_DONE;
          quot_d   = shreg_next;
          remout_d = rem_next[WIDTH-1:0];
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      shreg_q   <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      remout_q  <= '0;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
      dbz_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      shreg_q   <= shreg_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      remout_q  <= remout_d;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
      dbz_q     <= dbz_d;
`endif
    end
  end

  assign bus.busy      = (state_q == S_CALC);
  assign bus.done      = (state_q == S_DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = remout_q;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider (WIDTH=8)

module tb_seq_divider;

  localparam int W = 8;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  localparam int ZC = 1;
`else
  localparam int ZC = 0;
`endif

  typedef struct {
    int q;
    int r;
    int dbz;
    int lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   acc[$];
  int   cyc        = 0;
  int   vectors    = 0;
  int   miscompares = 0;
  int   prev_busy  = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int q, input int r, input int dbz, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.lat = lat;
    return e;
  endfunction

  // Edge counter plus a record of the edge at which each start was accepted.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n && bus.start && !bus.busy) acc.push_back(cyc);
  end

  // Monitor: every done pulse pops one expectation and checks result and shape.
  initial begin : monitor
    exp_t e;
    int   a;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.done) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got done=1, expected no pending operation");
          end else begin
            e = sb.pop_front();
            a = (acc.size() != 0) ? acc.pop_front() : -1000;
            chk("quotient",     int'(bus.quotient),    e.q);
            chk("remainder",    int'(bus.remainder),   e.r);
            chk("div_by_zero",  int'(bus.div_by_zero), e.dbz);
            chk("latency",      cyc - a + 1,           e.lat);
            chk("busy_at_done", int'(bus.busy),        0);
            chk("busy_before_done", prev_busy,         (e.lat > 1) ? 1 : 0);
          end
        end
        prev_busy = int'(bus.busy);
      end else begin
        prev_busy = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wait_idle_timeout", n, 0);
  endtask

  task automatic do_div(input int a, input int b, input exp_t e);
    wait_idle();
    bus.dividend = 8'(a);
    bus.divisor  = 8'(b);
    bus.start    = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin : stim
    int   n;
    int   a;
    int   b;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",      int'(bus.busy),        0);
    chk("rst_done",      int'(bus.done),        0);
    chk("rst_quotient",  int'(bus.quotient),    0);
    chk("rst_remainder", int'(bus.remainder),   0);
    chk("rst_dbz",       int'(bus.div_by_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, hand-computed
    do_div(200, 7,   mk(28,  4,  0, 9));
    do_div(255, 1,   mk(255, 0,  0, 9));
    do_div(5,   9,   mk(0,   5,  0, 9));
    do_div(255, 255, mk(1,   0,  0, 9));
    do_div(0,   0,   mk(255, 0,  ZC, (ZC != 0) ? 1 : 9));
    do_div(77,  0,   mk(255, 77, ZC, (ZC != 0) ? 1 : 9));
    do_div(1,   1,   mk(1,   0,  0, 9));

    // start held high through 100/3; operands changed mid-CALC must be ignored,
    // then the still-high start in the done cycle launches 9/2 back-to-back.
    wait_idle();
    bus.dividend = 8'd100;
    bus.divisor  = 8'd3;
    bus.start    = 1'b1;
    sb.push_back(mk(33, 1, 0, 9));
    sb.push_back(mk(4,  1, 0, 9));
    @(negedge clk);
    bus.dividend = 8'd9;
    bus.divisor  = 8'd2;
    n = 0;
    while (!bus.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("held_start_timeout", n, 0);
    @(negedge clk);
    bus.start = 1'b0;

    // Reset in the middle of 200/7
    wait_idle();
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",      int'(bus.busy),        0);
    chk("midrst_done",      int'(bus.done),        0);
    chk("midrst_quotient",  int'(bus.quotient),    0);
    chk("midrst_remainder", int'(bus.remainder),   0);
    chk("midrst_dbz",       int'(bus.div_by_zero), 0);
    acc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    do_div(50, 6, mk(8, 2, 0, 9));

    // Random sweep against the arithmetic reference
    for (int i = 0; i < 2000; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(1, 255));
      do_div(a, b, mk(a / b, a % b, 0, 9));
    end

    // Drain outstanding results
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_pending", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
